// File: rtl/track_pkg.sv
// Obstacle slot record and the colour tables shared by the track renderer and its bench.
package track_pkg;

  typedef struct packed {
    logic [1:0] obs_type;
    logic [9:0] position;
    logic [1:0] lane;
    logic       active;
  } obstacle_t;

  localparam logic [11:0] TYPE0_COLOUR = 12'hF00;
  localparam logic [11:0] TYPE1_COLOUR = 12'h0F0;
  localparam logic [11:0] TYPE2_COLOUR = 12'h00F;
  localparam logic [11:0] TYPE3_COLOUR = 12'hFF0;

  localparam logic [11:0] LANE0_BG = 12'h222;
  localparam logic [11:0] LANE1_BG = 12'h444;
  localparam logic [11:0] LANE2_BG = 12'h666;
  localparam logic [11:0] LANE3_BG = 12'h888;

  function automatic logic [11:0] type_colour(input logic [1:0] obs_type);
    logic [11:0] c;
    unique case (obs_type)
      2'd0:    c = TYPE0_COLOUR;
      2'd1:    c = TYPE1_COLOUR;
      2'd2:    c = TYPE2_COLOUR;
      default: c = TYPE3_COLOUR;
    endcase
    return c;
  endfunction

  function automatic logic [11:0] lane_colour(input logic [1:0] lane);
    logic [11:0] c;
    unique case (lane)
      2'd0:    c = LANE0_BG;
      2'd1:    c = LANE1_BG;
      2'd2:    c = LANE2_BG;
      default: c = LANE3_BG;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/obstacle_priority_select.sv
// Lowest-index winner select over a hit vector.
module obstacle_priority_select #(
  parameter int unsigned NUM_SLOTS   = 10,
  parameter int unsigned INDEX_WIDTH = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic [NUM_SLOTS-1:0]   hit,
  output logic                   valid,
  output logic [INDEX_WIDTH-1:0] index
);

  // Scan downward so the last assignment made is the lowest hitting index.
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
      if (hit[i]) begin
        valid = 1'b1;
        index = INDEX_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/track_renderer.sv
// Three-stage lane/obstacle pixel renderer with per-frame obstacle shadowing.
// Define TRACK_RENDERER_BLINK_EN to blink type-3 obstacles on frame_count[4].
module track_renderer
  import track_pkg::*;
#(
  parameter int unsigned SCREEN_WIDTH    = 1024,
  parameter int unsigned SCREEN_HEIGHT   = 768,
  parameter int unsigned NUM_LANES       = 3,
  parameter int unsigned NUM_OBSTACLES   = 10,
  parameter int unsigned OBSTACLE_MARGIN = 10
) (
  input  logic                            system_clock_in,
  input  logic                            reset_in,
  input  logic [10:0]                     hcount,
  input  logic [9:0]                      vcount,
  input  logic                            hsync,
  input  logic                            vsync,
  input  logic                            blank,
  input  obstacle_t [NUM_OBSTACLES-1:0]   obstacles,
  output logic [11:0]                     rgb,
  output logic                            hsync_out,
  output logic                            vsync_out,
  output logic                            blank_out
);

  localparam int unsigned LANE_HEIGHT     = SCREEN_HEIGHT / NUM_LANES;
  localparam int unsigned OBSTACLE_HEIGHT = LANE_HEIGHT - OBSTACLE_MARGIN;
  localparam int unsigned OBSTACLE_WIDTH  = OBSTACLE_HEIGHT;
  localparam int unsigned HALF_MARGIN     = OBSTACLE_MARGIN / 2;
  localparam int unsigned INDEX_WIDTH     = (NUM_OBSTACLES > 1) ? $clog2(NUM_OBSTACLES) : 1;

  obstacle_t [NUM_OBSTACLES-1:0] shadow_q;
  logic                          vsync_q;
  logic [7:0]                    frame_count;
  logic                          frame_edge;

  assign frame_edge = vsync & ~vsync_q;

  always_ff @(posedge system_clock_in or posedge reset_in) begin
    if (reset_in) begin
      vsync_q     <= 1'b0;
      frame_count <= 8'd0;
      shadow_q    <= '0;
    end else begin
      vsync_q <= vsync;
      if (frame_edge) begin
        shadow_q    <= obstacles;
        frame_count <= frame_count + 8'd1;
      end
    end
  end

  // Stage 1: row lane, visibility and per-slot hit compare against the shadow copy.
  logic [NUM_OBSTACLES-1:0]      hit_d;
  logic [NUM_OBSTACLES-1:0][1:0] type_d;
  logic [1:0]                    row_lane;
  logic                          visible;

  always_comb begin
    int unsigned vc_int;
    int unsigned lane_int;
    int unsigned row_top;
    int unsigned pos_end;
    vc_int   = 32'(vcount);
    lane_int = vc_int / LANE_HEIGHT;
    if (lane_int > NUM_LANES - 1) lane_int = NUM_LANES - 1;
    row_lane = lane_int[1:0];
    row_top  = lane_int * LANE_HEIGHT + HALF_MARGIN;
    visible  = (32'(hcount) < SCREEN_WIDTH) && (vc_int < SCREEN_HEIGHT);
    hit_d    = '0;
    type_d   = '0;
    for (int i = 0; i < int'(NUM_OBSTACLES); i++) begin
      pos_end   = 32'(12'(shadow_q[i].position) + 12'(OBSTACLE_WIDTH));
      type_d[i] = shadow_q[i].obs_type;
      hit_d[i]  = shadow_q[i].active
               && (32'(shadow_q[i].lane) < NUM_LANES)
               && (shadow_q[i].lane == row_lane)
               && (32'(shadow_q[i].position) <= 32'(hcount))
               && (32'(hcount) < pos_end)
               && (vc_int >= row_top)
               && (vc_int < row_top + OBSTACLE_HEIGHT);
`ifdef TRACK_RENDERER_BLINK_EN
      if ((shadow_q[i].obs_type == 2'd3) && frame_count[4]) hit_d[i] = 1'b0;
`endif
    end
  end

  logic [NUM_OBSTACLES-1:0]      hit_q;
  logic [NUM_OBSTACLES-1:0][1:0] type_q;
  logic [1:0]                    lane1_q, lane2_q, type2_q;
  logic                          visible1_q, visible2_q, valid2_q;
  logic [2:0]                    sync1_q, sync2_q;  // {hsync, vsync, blank}
  logic                          win_valid;
  logic [INDEX_WIDTH-1:0]        win_index;
  logic [11:0]                   rgb_d;

  // Stage 2: lowest-index winner.
  obstacle_priority_select #(
    .NUM_SLOTS   (NUM_OBSTACLES),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_select (
    .hit   (hit_q),
    .valid (win_valid),
    .index (win_index)
  );

  // Stage 3: colour.
  always_comb begin
    rgb_d = '0;
    if (!sync2_q[0] && visible2_q) begin
      rgb_d = valid2_q ? type_colour(type2_q) : lane_colour(lane2_q);
    end
  end

  always_ff @(posedge system_clock_in or posedge reset_in) begin
    if (reset_in) begin
      hit_q      <= '0;
      type_q     <= '0;
      lane1_q    <= 2'd0;
      visible1_q <= 1'b0;
      sync1_q    <= 3'b001;
      valid2_q   <= 1'b0;
      type2_q    <= 2'd0;
      lane2_q    <= 2'd0;
      visible2_q <= 1'b0;
      sync2_q    <= 3'b001;
      rgb        <= 12'd0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      blank_out  <= 1'b1;
    end else begin
      hit_q      <= hit_d;
      type_q     <= type_d;
      lane1_q    <= row_lane;
      visible1_q <= visible;
      sync1_q    <= {hsync, vsync, blank};
      valid2_q   <= win_valid;
      type2_q    <= win_valid ? type_q[win_index] : 2'd0;
      lane2_q    <= lane1_q;
      visible2_q <= visible1_q;
      sync2_q    <= sync1_q;
      rgb        <= rgb_d;
      hsync_out  <= sync2_q[2];
      vsync_out  <= sync2_q[1];
      blank_out  <= sync2_q[0];
    end
  end

endmodule

// File: doc/track_renderer.md
TRACK_RENDERER -- requirements
Module: track_renderer

Interface
REQ-001 Parameter SCREEN_WIDTH, default 1024, SHALL be the visible pixel columns.
REQ-002 Parameter SCREEN_HEIGHT, default 768, SHALL be the visible pixel rows.
REQ-003 Parameter NUM_LANES, default 3, range 1..4, SHALL be the number of horizontal lanes.
REQ-004 Parameter NUM_OBSTACLES, default 10, SHALL be the number of obstacle slots.
REQ-005 Parameter OBSTACLE_MARGIN, default 10, SHALL be the total vertical gap between an obstacle and its lane edges.
REQ-006 system_clock_in  input  1  SHALL be the single pixel clock; all logic on its rising edge.
REQ-007 reset_in  input  1  SHALL be the asynchronous, active-high reset.
REQ-008 hcount, vcount  input  11, 10  SHALL be the current pixel column and row.
REQ-009 hsync, vsync, blank  input  1 each  SHALL be the video timing, all active-high.
REQ-010 obstacles  input  NUM_OBSTACLES x 15  SHALL carry type[14:13], position[12:3], lane[2:1] and active[0].
REQ-011 rgb  output  12  SHALL be the registered pixel colour, 4 bits each for R, G and B.
REQ-012 hsync_out, vsync_out, blank_out  output  1 each  SHALL be the timing inputs delayed to align with rgb.

Function
REQ-013 A frame edge SHALL be the first cycle vsync is high after being low, detected against a registered copy of vsync.
REQ-014 On a frame edge the block SHALL copy all obstacle slots into shadow registers; that cycle's pixels SHALL use the old shadow copy.
REQ-015 Pixel evaluation SHALL use only the shadow copy; input changes without a frame edge SHALL NOT affect output.
REQ-016 LANE_HEIGHT SHALL be SCREEN_HEIGHT/NUM_LANES; OBSTACLE_HEIGHT SHALL be LANE_HEIGHT-OBSTACLE_MARGIN; OBSTACLE_WIDTH SHALL equal OBSTACLE_HEIGHT.
REQ-017 A slot SHALL hit when all of these hold: active=1; lane<NUM_LANES; lane matches the row's lane; position<=hcount<position+OBSTACLE_WIDTH (12-bit sum, no wrap); row within [laneTop+MARGIN/2, laneTop+MARGIN/2+OBSTACLE_HEIGHT).
REQ-018 Among hitting slots, the lowest slot index SHALL win.
REQ-019 Type colours SHALL be 0=12'hF00, 1=12'h0F0, 2=12'h00F and 3=12'hFF0; lane backgrounds SHALL be 12'h222, 12'h444, 12'h666 and 12'h888 for lanes 0..3.
REQ-020 rgb SHALL be 0 when the delayed blank is high or when hcount>=SCREEN_WIDTH or vcount>=SCREEN_HEIGHT; otherwise the winner's colour, or the lane background when nothing hits.
REQ-021 The pipeline SHALL have three stages (lane/hit compare, priority select, colour), giving exactly 3 cycles from inputs to rgb and the *_out signals.
REQ-022 An 8-bit frame_count SHALL increment on each frame edge and wrap from 255 to 0.

Reset
REQ-023 While reset_in is high: rgb=0, hsync_out=0, vsync_out=0, blank_out=1, all pipeline stages cleared, every shadow active bit cleared, frame_count=0, registered vsync=0.
REQ-024 After reset releases mid-frame, no obstacle SHALL be drawn until the next frame edge; backgrounds SHALL appear after 3 cycles.

Configuration
REQ-025 With macro TRACK_RENDERER_BLINK_EN defined, type-3 obstacles SHALL be drawn only while frame_count[4]=0; without it, type-3 obstacles SHALL always be drawn.

Structure
REQ-026 Package track_pkg SHALL hold the obstacle_t packed struct (field layout per REQ-010), the type colour constants and the lane background constants.
REQ-027 Sub-module obstacle_priority_select SHALL implement the parametrised lowest-index winner select (hit vector in; valid and index out).

Verification
REQ-028 After reset, no obstacles, pixel (100,300) -> rgb=12'h444 and blank_out=0 exactly 3 cycles later.
REQ-029 Slot 2 {type0, pos200, lane1} loaded via a frame edge -> (200,300)=12'hF00; (199,300)=12'h444; (446,300)=12'h444; (200,260)=12'h444; (200,261)=12'hF00.
REQ-030 Slots 0 {type1} and 5 {type2} at the same pos/lane -> 12'h0F0.
REQ-031 Change slot 2 to inactive mid-frame -> 12'hF00 persists until the first frame after the next vsync rise, then 12'h444.
REQ-032 Type-3 obstacle with the macro defined -> 12'hFF0 for frames 0-15, background for frames 16-31; without the macro -> 12'hFF0 in all frames.
REQ-033 Assert reset_in mid-line -> rgb=0 and blank_out=1 in the same cycle; after release, the REQ-029 obstacle is absent until the next frame edge.
